// File: rtl/bus_master_if.sv
// Bundles the host request/response channels and the register-bus command signals of bus_master.
// The master modport is the bus_master side; the slave modport is the host plus responder side.
interface bus_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              bus_cmd_valid;
  logic              bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              busy;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, bus_rd_data,
    output req_ready, rsp_valid, rsp_rdata, bus_cmd_valid, bus_op, bus_addr, bus_wr_data, busy
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, bus_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, bus_cmd_valid, bus_op, bus_addr, bus_wr_data, busy
  );
endinterface

// File: rtl/bus_master.sv
// Register-bus initiator: queues host requests in a small FIFO, issues one-cycle bus commands
// in order and returns read data through a valid/ready response channel (reads are blocking).
module bus_master #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic         clk,
  input  logic         rst,
  bus_master_if.master bif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [LAT_W-1:0] LAT_ZERO_C = LAT_W'(0);
  localparam logic [LAT_W-1:0] LAT_ONE_C  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_LOAD_C = LAT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  logic              fifo_op_r   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;
  logic              push_s;
  logic              pop_s;

  state_t            state_r;
  state_t            state_next_s;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic [LAT_W-1:0]  lat_next_s;
  logic              cmd_valid_next_s;
  logic              capture_s;
  logic              rsp_valid_next_s;

  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              bus_cmd_valid_r;
  logic              bus_op_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wr_data_r;
  logic              busy_r;

  assign push_s = bif.req_valid & req_ready_r;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Request FIFO storage and pointers; a pushed entry is only visible to the FSM next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_op_r[i]   <= 1'b0;
        fifo_addr_r[i] <= {ADDR_W{1'b0}};
        fifo_data_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO_C;
    end else begin
      if (push_s) begin
        fifo_op_r[wr_ptr_r]   <= bif.req_op;
        fifo_addr_r[wr_ptr_r] <= bif.req_addr;
        fifo_data_r[wr_ptr_r] <= bif.req_wdata;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r <= count_next_s;
    end
  end

  // FSM next-state and control decode
  always_comb begin
    state_next_s     = state_r;
    lat_next_s       = lat_cnt_r;
    pop_s            = 1'b0;
    cmd_valid_next_s = 1'b0;
    capture_s        = 1'b0;
    rsp_valid_next_s = rsp_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO_C) begin
          pop_s            = 1'b1;
          cmd_valid_next_s = 1'b1;
          state_next_s     = ST_CMD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (!bus_op_r) begin
          lat_next_s   = LAT_LOAD_C;
          state_next_s = ST_WAIT;
        end else if (count_r != CNT_ZERO_C) begin
          pop_s            = 1'b1;
          cmd_valid_next_s = 1'b1;
          state_next_s     = ST_CMD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_r == LAT_ZERO_C) begin
          capture_s        = 1'b1;
          rsp_valid_next_s = 1'b1;
          state_next_s     = ST_RESP;
        end else begin
          lat_next_s = lat_cnt_r - LAT_ONE_C;
        end
      end
      ST_RESP: begin
        if (bif.rsp_ready) begin
          rsp_valid_next_s = 1'b0;
          state_next_s     = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        rsp_valid_next_s = 1'b0;
        state_next_s     = ST_IDLE;
      end
    endcase
  end

  // FSM state and read-latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      lat_cnt_r <= LAT_ZERO_C;
    end else begin
      state_r   <= state_next_s;
      lat_cnt_r <= lat_next_s;
    end
  end

  // Registered bus, response and status outputs; status is precomputed from next-cycle state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r     <= 1'b0;
      rsp_valid_r     <= 1'b0;
      rsp_rdata_r     <= {DATA_W{1'b0}};
      bus_cmd_valid_r <= 1'b0;
      bus_op_r        <= 1'b0;
      bus_addr_r      <= {ADDR_W{1'b0}};
      bus_wr_data_r   <= {DATA_W{1'b0}};
      busy_r          <= 1'b0;
    end else begin
      bus_cmd_valid_r <= cmd_valid_next_s;
      if (pop_s) begin
        bus_op_r      <= fifo_op_r[rd_ptr_r];
        bus_addr_r    <= fifo_addr_r[rd_ptr_r];
        bus_wr_data_r <= fifo_op_r[rd_ptr_r] ? fifo_data_r[rd_ptr_r] : {DATA_W{1'b0}};
      end
      if (capture_s) begin
        rsp_rdata_r <= bif.bus_rd_data;
      end
      rsp_valid_r <= rsp_valid_next_s;
      req_ready_r <= (count_next_s != DEPTH_C);
      busy_r      <= (count_next_s != CNT_ZERO_C) || (state_next_s != ST_IDLE);
    end
  end

  assign bif.req_ready     = req_ready_r;
  assign bif.rsp_valid     = rsp_valid_r;
  assign bif.rsp_rdata     = rsp_rdata_r;
  assign bif.bus_cmd_valid = bus_cmd_valid_r;
  assign bif.bus_op        = bus_op_r;
  assign bif.bus_addr      = bus_addr_r;
  assign bif.bus_wr_data   = bus_wr_data_r;
  assign bif.busy          = busy_r;
endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: directed scenarios plus randomized traffic against a
// queue-based reference model (RD_LAT=1 instance) and a latency check on an RD_LAT=3 instance.
module tb_bus_master;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();
  bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bif3 ();

  bus_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .bif(bif)
  );
  bus_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .bif(bif3)
  );

  // 1-cycle registered responder (16 registers, address aliased on the low 4 bits)
  logic [DW-1:0] resp_mem [16];
  logic [DW-1:0] resp_rd;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) resp_mem[i] <= 16'h0000;
      resp_rd <= 16'h0000;
    end else if (bif.bus_cmd_valid) begin
      if (bif.bus_op) resp_mem[bif.bus_addr[3:0]] <= bif.bus_wr_data;
      else            resp_rd <= resp_mem[bif.bus_addr[3:0]];
    end
  end
  assign bif.bus_rd_data  = resp_rd;
  assign bif3.bus_rd_data = 16'(cyc * 7 + 3);

  // reference model state
  typedef struct packed {
    logic        op;
    logic [15:0] addr;
    logic [15:0] data;
    int          acc_cyc;
  } cmd_t;

  cmd_t        exp_cmd_q [$];
  logic [15:0] exp_rsp_q [$];
  int          cmd_cyc_q [$];
  logic [15:0] model_mem [16];
  int          n_acc = 0;
  int          n_cmd = 0;
  bit          read_out = 1'b0;
  bit          rsp_seen = 1'b0;
  int          rd_cmd_cyc = 0;
  int          last_lat = 0;
  logic        last_req_ready = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    n_acc    = 0;
    n_cmd    = 0;
    read_out = 1'b0;
    rsp_seen = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_req_ready"},     32'(bif.req_ready),     32'd0);
    check_eq({pfx, "_rsp_valid"},     32'(bif.rsp_valid),     32'd0);
    check_eq({pfx, "_rsp_rdata"},     32'(bif.rsp_rdata),     32'd0);
    check_eq({pfx, "_bus_cmd_valid"}, 32'(bif.bus_cmd_valid), 32'd0);
    check_eq({pfx, "_bus_op"},        32'(bif.bus_op),        32'd0);
    check_eq({pfx, "_bus_addr"},      32'(bif.bus_addr),      32'd0);
    check_eq({pfx, "_bus_wr_data"},   32'(bif.bus_wr_data),   32'd0);
    check_eq({pfx, "_busy"},          32'(bif.busy),          32'd0);
    check_eq({pfx, "_dut3_busy"},     32'(bif3.busy),         32'd0);
    check_eq({pfx, "_dut3_req_ready"}, 32'(bif3.req_ready),   32'd0);
  endtask

  // One cycle: check outputs against the model at the falling edge, then drive the next inputs
  task automatic step(input logic v, input logic op, input logic [15:0] addr,
                      input logic [15:0] data, input logic rrdy);
    cmd_t c;
    int   occ;
    bit   cmd_now;
    @(negedge clk);
    cmd_now = bif.bus_cmd_valid;
    if (cmd_now) begin
      check_eq("cmd_expected", 32'(exp_cmd_q.size() > 0), 32'd1);
      check_eq("cmd_while_read", 32'(read_out), 32'd0);
      if (exp_cmd_q.size() > 0) begin
        c = exp_cmd_q.pop_front();
        check_eq("bus_op",      32'(bif.bus_op),      32'(c.op));
        check_eq("bus_addr",    32'(bif.bus_addr),    32'(c.addr));
        check_eq("bus_wr_data", 32'(bif.bus_wr_data), 32'(c.data));
        last_lat = cyc - c.acc_cyc;
        check_eq("cmd_min_latency", 32'(last_lat >= 2), 32'd1);
      end
      n_cmd++;
      cmd_cyc_q.push_back(cyc);
      if (!bif.bus_op) begin
        read_out   = 1'b1;
        rsp_seen   = 1'b0;
        rd_cmd_cyc = cyc;
      end
    end
    occ = n_acc - n_cmd;
    check_eq("req_ready", 32'(bif.req_ready), 32'(occ != 4));
    check_eq("busy", 32'(bif.busy), 32'((occ != 0) || cmd_now || read_out));
    if (bif.rsp_valid) begin
      check_eq("rsp_expected", 32'(exp_rsp_q.size() > 0), 32'd1);
      if (exp_rsp_q.size() > 0) check_eq("rsp_rdata", 32'(bif.rsp_rdata), 32'(exp_rsp_q[0]));
      if (!rsp_seen) begin
        check_eq("rsp_latency", 32'(cyc - rd_cmd_cyc), 32'd2);
        rsp_seen = 1'b1;
      end
    end
    bif.rsp_ready = rrdy;
    if (bif.rsp_valid && rrdy) begin
      if (exp_rsp_q.size() > 0) exp_rsp_q.delete(0);
      read_out = 1'b0;
    end
    last_req_ready = bif.req_ready;
    bif.req_valid  = v;
    bif.req_op     = op;
    bif.req_addr   = addr;
    bif.req_wdata  = data;
    if (v && bif.req_ready) begin
      n_acc++;
      c.op      = op;
      c.addr    = addr;
      c.data    = op ? data : 16'h0000;
      c.acc_cyc = cyc;
      exp_cmd_q.push_back(c);
      if (op) model_mem[addr[3:0]] = data;
      else    exp_rsp_q.push_back(model_mem[addr[3:0]]);
    end
  endtask

  task automatic drain(input int budget);
    int  i;
    bit  done;
    done = 1'b0;
    for (i = 0; i < budget && !done; i++) begin
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      done = (exp_cmd_q.size() == 0) && (exp_rsp_q.size() == 0) && !read_out;
    end
    check_eq("drain_done", 32'(done), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    int   acc0;
    int   c3;
    int   r3;
    logic [15:0] rd3;
    bif.req_valid  = 1'b0; bif.req_op  = 1'b0; bif.req_addr  = 16'h0000; bif.req_wdata  = 16'h0000;
    bif.rsp_ready  = 1'b1;
    bif3.req_valid = 1'b0; bif3.req_op = 1'b0; bif3.req_addr = 16'h0000; bif3.req_wdata = 16'h0000;
    bif3.rsp_ready = 1'b1;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    rst = 1'b0;
    @(posedge clk);

    // single write from idle: command two cycles after acceptance, exactly one strobe
    n0 = n_cmd;
    step(1'b1, 1'b1, 16'h0009, 16'h0001, 1'b1);
    drain(20);
    check_eq("t1_latency", 32'(last_lat), 32'd2);
    check_eq("t1_cmd_count", 32'(n_cmd - n0), 32'd1);

    // write then reads through the responder
    step(1'b1, 1'b1, 16'h0009, 16'h0001, 1'b1);
    step(1'b1, 1'b0, 16'h0009, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1);
    drain(40);

    // three back-to-back writes give consecutive command cycles
    step(1'b1, 1'b1, 16'h0001, 16'h00a1, 1'b1);
    step(1'b1, 1'b1, 16'h0002, 16'h00a2, 1'b1);
    step(1'b1, 1'b1, 16'h0003, 16'h00a3, 1'b1);
    drain(20);
    check_eq("t3_back_to_back", 32'(cmd_cyc_q[cmd_cyc_q.size()-1] - cmd_cyc_q[cmd_cyc_q.size()-3]), 32'd2);
    check_eq("t3_busy", 32'(bif.busy), 32'd0);

    // response stalled: FIFO fills to 4, no command until the handshake
    step(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
    for (int i = 0; i < 10 && !bif.rsp_valid; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check_eq("t4_rsp_seen", 32'(bif.rsp_valid), 32'd1);
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'(10 + i), 16'($urandom), 1'b0);
    check_eq("t4_accepted", 32'(n_acc - acc0), 32'd4);
    check_eq("t4_full_on_5th", 32'(last_req_ready), 32'd0);
    n0 = n_cmd;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check_eq("t4_no_cmd_stalled", 32'(n_cmd - n0), 32'd0);
    drain(40);

    // reset during the wait phase of a read
    step(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1);
    for (int i = 0; i < 6 && !read_out; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    check_eq("t5_cmd_seen", 32'(read_out), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs_zero("t5_async");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    check_eq("t5_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check_eq("t5_cmd_valid", 32'(bif.bus_cmd_valid), 32'd0);
    check_eq("t5_busy", 32'(bif.busy), 32'd0);
    check_eq("t5_req_ready", 32'(bif.req_ready), 32'd1);
    n0 = n_cmd;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    check_eq("t5_no_cmd_after_rst", 32'(n_cmd - n0), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom),
           1'(($urandom % 4) != 0));
    end
    drain(200);
    check_eq("final_busy", 32'(bif.busy), 32'd0);

    // RD_LAT=3: capture the responder value of cycle C+3, response in cycle C+4
    @(negedge clk);
    bif3.req_valid = 1'b1; bif3.req_op = 1'b0; bif3.req_addr = 16'h0007;
    @(negedge clk);
    bif3.req_valid = 1'b0;
    c3  = -1;
    r3  = -1;
    rd3 = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif3.bus_cmd_valid && c3 < 0) begin
        c3 = cyc;
        check_eq("t6_bus_op", 32'(bif3.bus_op), 32'd0);
        check_eq("t6_bus_wr_data", 32'(bif3.bus_wr_data), 32'd0);
        check_eq("t6_bus_addr", 32'(bif3.bus_addr), 32'h0007);
      end
      if (bif3.rsp_valid && r3 < 0) begin
        r3  = cyc;
        rd3 = bif3.rsp_rdata;
      end
    end
    check_eq("t6_seen", 32'((c3 >= 0) && (r3 >= 0)), 32'd1);
    check_eq("t6_rsp_cycle", 32'(r3 - c3), 32'd4);
    check_eq("t6_rdata", 32'(rd3), 32'(16'((c3 + 3) * 7 + 3)));
    check_eq("t6_busy", 32'(bif3.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
